// File: rtl/pol2rec.sv
// Polar-to-rectangular converter: iterative CORDIC in rotation mode, one
// micro-rotation per enabled clock, 16Q16 modulus and 8Q24 degree angle in.
module pol2rec #(
  parameter int          NITER    = 32,
  parameter logic [31:0] INV_GAIN = 32'd2608131496
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               start,
  input  logic signed [31:0] mod,
  input  logic signed [31:0] angle,
  output logic signed [31:0] x,
  output logic signed [31:0] y,
  output logic               busy,
  output logic               done
);

  localparam logic [4:0]         LAST     = 5'(NITER - 1);
  localparam logic signed [31:0] DEG90    = 32'sd1509949440;
  localparam logic signed [65:0] GAIN_EXT = {34'd0, INV_GAIN};

  logic signed [39:0] xr, yr;
  logic signed [31:0] zr;
  logic [4:0]         cnt;

  logic signed [65:0] mod_ext;
  logic signed [39:0] p;
  logic signed [39:0] x0, y0;
  logic signed [31:0] z0;
  logic signed [39:0] xs, ys;
  logic signed [39:0] xn, yn;
  logic signed [31:0] zn;
  logic signed [31:0] atan_i;

  // Pre-scale by 1/K so the CORDIC gain cancels; 16Q16 * 0Q32 >>> 26 lands on Q22.
  assign mod_ext = {{34{mod[31]}}, mod};
  assign p       = 40'((mod_ext * GAIN_EXT) >>> 26);

  // NOTE: every output of a combinational block gets a default first so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    x0 = p;
    y0 = '0;
    z0 = angle;
    if (angle > DEG90) begin
      x0 = '0;
      y0 = p;
      z0 = angle - DEG90;
    end else if (angle < -DEG90) begin
      x0 = '0;
      y0 = -p;
      z0 = angle + DEG90;
    end
  end

  // atan(2^-i) in degrees, 8Q24, rounded to nearest.
  always_comb begin
    atan_i = '0;
    case (cnt)
      5'd0:  atan_i = 32'sd754974720;
      5'd1:  atan_i = 32'sd445687602;
      5'd2:  atan_i = 32'sd235489088;
      5'd3:  atan_i = 32'sd119537938;
      5'd4:  atan_i = 32'sd60000934;
      5'd5:  atan_i = 32'sd30029717;
      5'd6:  atan_i = 32'sd15018523;
      5'd7:  atan_i = 32'sd7509720;
      5'd8:  atan_i = 32'sd3754917;
      5'd9:  atan_i = 32'sd1877466;
      5'd10: atan_i = 32'sd938734;
      5'd11: atan_i = 32'sd469367;
      5'd12: atan_i = 32'sd234684;
      5'd13: atan_i = 32'sd117342;
      5'd14: atan_i = 32'sd58671;
      5'd15: atan_i = 32'sd29335;
      5'd16: atan_i = 32'sd14668;
      5'd17: atan_i = 32'sd7334;
      5'd18: atan_i = 32'sd3667;
      5'd19: atan_i = 32'sd1833;
      5'd20: atan_i = 32'sd917;
      5'd21: atan_i = 32'sd458;
      5'd22: atan_i = 32'sd229;
      5'd23: atan_i = 32'sd115;
      5'd24: atan_i = 32'sd57;
      5'd25: atan_i = 32'sd29;
      5'd26: atan_i = 32'sd14;
      5'd27: atan_i = 32'sd7;
      5'd28: atan_i = 32'sd4;
      5'd29: atan_i = 32'sd2;
      5'd30: atan_i = 32'sd1;
      default: atan_i = 32'sd0;
    endcase
  end

  always_comb begin
    xs = xr >>> cnt;
    ys = yr >>> cnt;
    if (!zr[31]) begin
      xn = xr - ys;
      yn = yr + xs;
      zn = zr - atan_i;
    end else begin
      xn = xr + ys;
      yn = yr - xs;
      zn = zr + atan_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xr   <= '0;
      yr   <= '0;
      zr   <= '0;
      cnt  <= '0;
      x    <= '0;
      y    <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (enable) begin
      if (start) begin
        // A new start always wins, including over an in-flight final iteration.
        xr   <= x0;
        yr   <= y0;
        zr   <= z0;
        cnt  <= '0;
        busy <= 1'b1;
        done <= 1'b0;
      end else if (busy) begin
        xr <= xn;
        yr <= yn;
        zr <= zn;
        if (cnt == LAST) begin
          x    <= xn[37:6];
          y    <= yn[37:6];
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + 5'd1;
        end
      end else begin
        done <= 1'b0;
      end
    end
  end

endmodule
